// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with increment, stall hold, redirect load and flush pulse.
// Optional PC_MISALIGN_CHECK_EN traps misaligned redirect targets to TRAP_VECTOR.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INC          = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h80
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic [XLEN-1:0] pc_prev,
    output logic            flush_o,
    output logic            misalign_o
);
    localparam logic [XLEN-1:0] INC_W = XLEN'(INC);
    logic [XLEN-1:0] pc_q, pc_d, prev_q, prev_d, tgt;
    logic            flush_q;
`ifdef PC_MISALIGN_CHECK_EN
    logic mis_q, mis_d;
    always_comb begin
        mis_d = redirect_i && (target_i[1:0] != 2'b00);
        tgt   = mis_d ? TRAP_VECTOR : target_i;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    assign misalign_o = mis_q;
`else
    logic unused_bits;
    assign unused_bits = ^{TRAP_VECTOR, target_i[1:0]};
    assign tgt         = {target_i[XLEN-1:2], 2'b00};
    assign misalign_o  = 1'b0;
`endif
    // pc_prev only moves when the PC actually changes, so a redirect to the current PC keeps it.
    always_comb begin
        pc_d   = redirect_i ? tgt : stall_i ? pc_q : pc_q + INC_W;
        prev_d = (pc_d != pc_q) ? pc_q : prev_q;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            prev_q  <= RESET_VECTOR;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            prev_q  <= prev_d;
            flush_q <= redirect_i;
        end
    assign pc_out      = pc_q;
    assign pc_next     = pc_d;
    assign pc_plus_inc = pc_q + INC_W;
    assign pc_prev     = prev_q;
    assign flush_o     = flush_q;
endmodule
